// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3-256 single-block pad/transmit path.
package sha3_pkg;
  localparam int RATE_BYTES = 136;
  localparam int BEAT_W = 200;
  localparam int NBEATS = 8;
  localparam int STATE_BYTES = NBEATS * BEAT_W / 8;
  localparam logic [7:0] DOMAIN_PAD = 8'h06;
  localparam logic [7:0] FINAL_PAD = 8'h80;

  typedef enum logic [1:0] {ACCUM, PAD, SEND, DROP} tx_state_t;
  typedef logic [NBEATS-1:0][BEAT_W-1:0] state1600_t;
  // Same 1600 bits viewed as bytes: byte k sits at bits [8k+7:8k].
  typedef logic [STATE_BYTES-1:0][7:0] state_bytes_t;
endpackage

// File: rtl/sha3_byte_insert.sv
// Combinational: writes up to 8 message bytes at a byte offset into the state.
// Bytes that would land at or beyond the rate boundary are masked off.
module sha3_byte_insert
  import sha3_pkg::*;
(
  input  state1600_t  state_i,
  input  logic [7:0]  offset_i,
  input  logic [63:0] data_i,
  input  logic [3:0]  nbytes_i,
  output state1600_t  state_o
);

  state_bytes_t bytes_w;
  logic [8:0]   pos;

  always_comb begin
    bytes_w = state_i;
    pos     = '0;
    for (int j = 0; j < 8; j++) begin
      pos = {1'b0, offset_i} + 9'(j);
      if ((4'(j) < nbytes_i) && (pos < 9'(RATE_BYTES))) begin
        bytes_w[pos[7:0]] = data_i[8*j +: 8];
      end
    end
    state_o = bytes_w;
  end

endmodule

// File: rtl/sha3_pad_tx.sv
// Packs a byte stream into one SHA3-256 block, pads it and emits 8 beats to perm.
// Last word at edge T -> beat0 in T+2, beat7 in T+9; msg_stall holds off the source meanwhile.
module sha3_pad_tx
  import sha3_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              msg_push,
  input  logic [63:0]       msg_data,
  input  logic [3:0]        msg_nbytes,
  input  logic              msg_last,
  output logic              msg_stall,
  output logic              pushout,
  output logic [2:0]        doutix,
  output logic [BEAT_W-1:0] dout,
  output logic              err_ovf
);

  tx_state_t         state_q;
  state1600_t        buf_q;
  state1600_t        ins_state;
  state1600_t        pad_state;
  state_bytes_t      pad_bytes;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [8:0]        cnt_sum;
  logic [3:0]        nb_eff;
  logic              accept;
  logic              stall_q;
  logic              pushout_q;
  logic              err_q;
  logic [2:0]        ix_q;
  logic [BEAT_W-1:0] dout_q;

  assign nb_eff  = (msg_nbytes > 4'd8) ? 4'd8 : msg_nbytes;
  assign cnt_sum = {1'b0, cnt_q} + {5'b0, nb_eff};
  assign cnt_d   = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
  assign accept  = msg_push && !stall_q && (state_q == ACCUM);

  sha3_byte_insert u_insert (
    .state_i  (buf_q),
    .offset_i (cnt_q),
    .data_i   (msg_data),
    .nbytes_i (nb_eff),
    .state_o  (ins_state)
  );

  // cnt_q is at most RATE_BYTES-1 whenever PAD is entered, so both ORs stay in the rate.
  always_comb begin
    pad_bytes = buf_q;
    pad_bytes[cnt_q] = pad_bytes[cnt_q] | DOMAIN_PAD;
    pad_bytes[RATE_BYTES-1] = pad_bytes[RATE_BYTES-1] | FINAL_PAD;
    pad_state = pad_bytes;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      buf_q     <= '0;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
      pushout_q <= 1'b0;
      err_q     <= 1'b0;
      ix_q      <= '0;
      dout_q    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (accept) begin
            buf_q <= ins_state;
            cnt_q <= cnt_d;
            if (msg_last) begin
              stall_q <= 1'b1;
              if (cnt_d <= 8'(RATE_BYTES - 1)) begin
                state_q <= PAD;
              end else begin
                state_q <= DROP;
                err_q   <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          buf_q     <= pad_state;
          pushout_q <= 1'b1;
          ix_q      <= '0;
          dout_q    <= pad_state[0];
          state_q   <= SEND;
        end
        SEND: begin
          if (ix_q == 3'(NBEATS - 1)) begin
            pushout_q <= 1'b0;
            dout_q    <= '0;
            ix_q      <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            state_q   <= ACCUM;
          end else begin
            ix_q   <= ix_q + 3'd1;
            dout_q <= buf_q[ix_q + 3'd1];
          end
        end
        DROP: begin
          buf_q   <= '0;
          cnt_q   <= '0;
          stall_q <= 1'b0;
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign msg_stall = stall_q;
  assign pushout   = pushout_q;
  assign doutix    = ix_q;
  assign dout      = dout_q;
  assign err_ovf   = err_q;

endmodule

// File: tb/tb_sha3_pad_tx.sv
// Scoreboard bench for sha3_pad_tx: directed messages, expected beats queued at acceptance.
module tb_sha3_pad_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         msg_push;
  logic [63:0]  msg_data;
  logic [3:0]   msg_nbytes;
  logic         msg_last;
  logic         msg_stall;
  logic         pushout;
  logic [2:0]   doutix;
  logic [199:0] dout;
  logic         err_ovf;

  sha3_pad_tx dut (
    .clk        (clk),
    .reset      (reset),
    .msg_push   (msg_push),
    .msg_data   (msg_data),
    .msg_nbytes (msg_nbytes),
    .msg_last   (msg_last),
    .msg_stall  (msg_stall),
    .pushout    (pushout),
    .doutix     (doutix),
    .dout       (dout),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   ix;
    logic [199:0] dat;
    int           cyc;
  } beat_t;

  localparam logic [199:0] BEAT5_FINAL = 200'h80_0000_0000_0000_0000_0000;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         err_exp = 0;
  logic       mon_en = 1'b0;
  logic       prev_push = 1'b0;
  logic [2:0] prev_ix = '0;
  beat_t      exp_q[$];
  beat_t      e;
  logic [7:0] mb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every beat on the output must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pushout === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat ix=%0d dat=%h", doutix, dout);
        end else begin
          e = exp_q.pop_front();
          if (doutix !== e.ix || dout !== e.dat) begin
            bad++;
            $display("FAIL beat ix act=%0d exp=%0d dat act=%h exp=%h", doutix, e.ix, dout, e.dat);
          end
          if (e.cyc >= 0) begin
            total++;
            if (cyc != e.cyc) begin
              bad++;
              $display("FAIL beat0_time act=%0d exp=%0d", cyc, e.cyc);
            end
          end
        end
        if (doutix !== 3'd0) begin
          total++;
          if (!(prev_push && prev_ix == doutix - 3'd1)) begin
            bad++;
            $display("FAIL beat_gap ix=%0d prev_push=%0b prev_ix=%0d", doutix, prev_push, prev_ix);
          end
        end
      end else begin
        total++;
        if (dout !== '0) begin
          bad++;
          $display("FAIL idle_dout act=%h exp=0", dout);
        end
      end
      if (err_ovf === 1'b1) begin
        total++;
        if (err_exp > 0) err_exp--;
        else begin
          bad++;
          $display("FAIL unexpected_err_ovf cyc=%0d", cyc);
        end
      end
      prev_push = pushout;
      prev_ix   = doutix;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic push_word(input logic [63:0] d, input logic [3:0] nb, input logic last,
                           output int acc, output int nst);
    int g;
    msg_push = 1'b1;
    msg_data = d;
    msg_nbytes = nb;
    msg_last = last;
    nst = 0;
    g = 0;
    while (msg_stall !== 1'b0 && g < 40) begin
      @(negedge clk);
      g++;
      nst++;
    end
    if (g >= 40) begin
      total++;
      bad++;
      $display("FAIL push_timeout act=stalled exp=accept");
    end
    @(negedge clk);
    acc = cyc;
    msg_push = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic send_msg(output int acc, output int nst0);
    int len, nw, nb, a, n;
    logic [63:0] d;
    len = mb.size();
    nw = (len == 0) ? 1 : (len + 7) / 8;
    a = 0;
    nst0 = 0;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      nb = len - 8 * w;
      if (nb > 8) nb = 8;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = mb[8*w + k];
      push_word(d, 4'(nb), (w == nw - 1), a, n);
      if (w == 0) nst0 = n;
    end
    acc = a;
  endtask

  // Reference padding: message bytes, 0x06 at offset len, 0x80 ORed into byte 135.
  task automatic expect_model(input int acc);
    logic [1599:0] st;
    beat_t b;
    int len;
    len = mb.size();
    st = '0;
    for (int k = 0; k < len; k++) st[8*k +: 8] = mb[k];
    st[8*len +: 8] = st[8*len +: 8] | 8'h06;
    st[8*135 +: 8] = st[8*135 +: 8] | 8'h80;
    for (int i = 0; i < 8; i++) begin
      b.ix = 3'(i);
      b.dat = st[200*i +: 200];
      b.cyc = (i == 0) ? acc + 1 : -1;
      exp_q.push_back(b);
    end
  endtask

  // Short messages: beat0 carries the data, beat5 only the final pad bit.
  task automatic expect_const(input int acc, input logic [199:0] b0);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.ix = 3'(i);
      b.dat = (i == 0) ? b0 : (i == 5) ? BEAT5_FINAL : '0;
      b.cyc = (i == 0) ? acc + 1 : -1;
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d exp=0", nm, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc, acc_a, acc_b, nst, g;
    reset = 1'b1;
    msg_push = 1'b0;
    msg_data = '0;
    msg_nbytes = '0;
    msg_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pushout", 256'(pushout), 256'(0));
    chk("rst_doutix", 256'(doutix), 256'(0));
    chk("rst_dout", 256'(dout), 256'(0));
    chk("rst_err_ovf", 256'(err_ovf), 256'(0));
    chk("rst_stall", 256'(msg_stall), 256'(0));
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // "abc"
    mb = {8'h61, 8'h62, 8'h63};
    send_msg(acc, nst);
    expect_const(acc, 200'h0663_6261);
    drain("abc");

    // empty message
    mb.delete();
    send_msg(acc, nst);
    expect_const(acc, 200'h06);
    drain("empty");

    // 135 bytes: byte 135 becomes 0x86
    mb.delete();
    repeat (135) mb.push_back(8'hA5);
    send_msg(acc, nst);
    expect_model(acc);
    drain("len135");

    // 136 bytes: overflow pulse, no beats, then a clean "abc"
    mb.delete();
    repeat (136) mb.push_back(8'h5A);
    err_exp = 1;
    send_msg(acc, nst);
    repeat (4) @(negedge clk);
    chk("ovf_pulse_seen", 256'(err_exp), 256'(0));
    mb = {8'h61, 8'h62, 8'h63};
    send_msg(acc, nst);
    expect_const(acc, 200'h0663_6261);
    drain("after_ovf");

    // back-to-back with push held through SEND
    mb = {8'h61, 8'h62, 8'h63};
    send_msg(acc_a, nst);
    expect_const(acc_a, 200'h0663_6261);
    mb = {8'h78, 8'h79};
    send_msg(acc_b, nst);
    expect_model(acc_b);
    chk("b2b_stall_cycles", 256'(nst), 256'(9));
    chk("b2b_accept_gap", 256'(acc_b - acc_a), 256'(10));
    drain("b2b");

    // reset in the middle of the beat train
    mb.delete();
    repeat (20) mb.push_back(8'h11);
    send_msg(acc, nst);
    expect_model(acc);
    g = 0;
    while (!(pushout === 1'b1 && doutix === 3'd3) && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("reach_beat3", 256'(doutix), 256'(3));
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk("midrst_pushout", 256'(pushout), 256'(0));
    chk("midrst_doutix", 256'(doutix), 256'(0));
    chk("midrst_stall", 256'(msg_stall), 256'(0));
    reset = 1'b0;
    @(negedge clk);
    mb = {8'h42};
    send_msg(acc, nst);
    expect_model(acc);
    drain("post_rst");

    chk("err_pending", 256'(err_exp), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
